// File: rtl/wb_regfile.sv
// wb_regfile: eight-entry writeback register file with a pending-write
// scoreboard and a retired-instruction counter.
// Optional feature: define WB_BYPASS_EN to forward DATA_IN to a read port
// that addresses the register being written in the same cycle.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [1:0]        OP_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [2:0]        DESTREG_IN,
  input  logic [2:0]        RADDR_A,
  input  logic [2:0]        RADDR_B,
  output logic [DATA_W-1:0] RDATA_A,
  output logic [DATA_W-1:0] RDATA_B,
  input  logic              ISSUE_VALID,
  input  logic [2:0]        ISSUE_REG,
  output logic [7:0]        BUSY,
  output logic              WB_WE,
  output logic [CNT_W-1:0]  RETIRED
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  logic [DATA_W-1:0] regs [8];
  logic [7:0]        busy_q;
  logic [7:0]        busy_next;
  logic [CNT_W-1:0]  retired_q;
  logic [DATA_W-1:0] array_a;
  logic [DATA_W-1:0] array_b;

  // Only ALU results and load data reach a register, and never R0.
  always_comb begin
    WB_WE = ((OP_IN == OP_ALU) || (OP_IN == OP_LOAD)) && (DESTREG_IN != 3'd0);
  end

  // Register array: R0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (WB_WE) begin
      regs[DESTREG_IN] <= DATA_IN;
    end
  end

  // Combinational reads; R0 is forced to zero regardless of storage.
  always_comb begin
    array_a = (RADDR_A == 3'd0) ? '0 : regs[RADDR_A];
    array_b = (RADDR_B == 3'd0) ? '0 : regs[RADDR_B];
  end

`ifdef WB_BYPASS_EN
  // Write-through: a read of the register being written sees the new value now.
  always_comb begin
    RDATA_A = (WB_WE && (RADDR_A == DESTREG_IN)) ? DATA_IN : array_a;
    RDATA_B = (WB_WE && (RADDR_B == DESTREG_IN)) ? DATA_IN : array_b;
  end
`else
  // No forwarding: reads return the stored value until the write edge.
  always_comb begin
    RDATA_A = array_a;
    RDATA_B = array_b;
  end
`endif

  // Scoreboard next state: clear the retiring register, then set the issuing
  // one so a newer pending writer to the same register wins.
  always_comb begin
    busy_next = busy_q;
    if (WB_WE) begin
      busy_next[DESTREG_IN] = 1'b0;
    end
    if (ISSUE_VALID && (ISSUE_REG != 3'd0)) begin
      busy_next[ISSUE_REG] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  // Every non-NOP retires, including stores and R0 writes; wraps silently.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      retired_q <= '0;
    end else if (OP_IN != OP_NOP) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign BUSY    = busy_q;
  assign RETIRED = retired_q;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: DATA_W, 16, register and data width in bits.
REQ-002 Parameter: CNT_W, 16, retired-instruction counter width in bits.
REQ-003 Port: CLOCK_50  input  1  clock; all state updates on its rising edge.
REQ-004 Port: RESET  input  1  reset, asynchronous, active-high.
REQ-005 Port: OP_IN  input  2  op from the MEM output latch: 00 NOP, 01 ALU, 10 LOAD, 11 STORE.
REQ-006 Port: DATA_IN  input  DATA_W  result from the MEM output latch: ALU result or load data.
REQ-007 Port: DESTREG_IN  input  3  destination register index from the MEM output latch.
REQ-008 Port: RADDR_A  input  3  decode read port A index.
REQ-009 Port: RADDR_B  input  3  decode read port B index.
REQ-010 Port: RDATA_A  output  DATA_W  read data for RADDR_A, combinational.
REQ-011 Port: RDATA_B  output  DATA_W  read data for RADDR_B, combinational.
REQ-012 Port: ISSUE_VALID  input  1  decode issues an instruction that writes ISSUE_REG.
REQ-013 Port: ISSUE_REG  input  3  destination index of the issuing instruction.
REQ-014 Port: BUSY  output  8  scoreboard; bit n set = write to Rn pending.
REQ-015 Port: WB_WE  output  1  combinational write enable for this cycle.
REQ-016 Port: RETIRED  output  CNT_W  count of retired non-NOP instructions.

Function
REQ-017 The register file SHALL hold eight DATA_W-bit registers R0..R7; R0 SHALL read as 0 and ignore writes.
REQ-018 WB_WE SHALL be 1 iff OP_IN is 01 or 10 and DESTREG_IN is not 0.
REQ-019 When WB_WE is 1, R[DESTREG_IN] SHALL take DATA_IN at the rising edge, giving a write latency of one edge.
REQ-020 OP_IN 00 and 11 SHALL leave the register file unchanged, regardless of DATA_IN and DESTREG_IN.
REQ-021 RDATA_A and RDATA_B SHALL be combinational reads of the current register contents; both ports may address the same register.
REQ-022 In the scoreboard, at each edge, BUSY[ISSUE_REG] SHALL be set if ISSUE_VALID is 1 and ISSUE_REG is not 0.
REQ-023 At each edge, BUSY[DESTREG_IN] SHALL be cleared if WB_WE is 1.
REQ-024 If the set and the clear target the same register in one edge, the set SHALL win, because the newer writer is pending.
REQ-025 Issue and retire on different registers in one edge SHALL both take effect.
REQ-026 BUSY[0] SHALL be constant 0.
REQ-027 Issuing to an already-busy register SHALL keep the bit set, with no error and no count.
REQ-028 RETIRED SHALL increment by 1 at each edge where OP_IN is not 00, including STOREs and writes to R0.
REQ-029 RETIRED SHALL wrap from 2^CNT_W-1 to 0 with no flag.

Reset
REQ-030 While RESET is 1, R0..R7, BUSY and RETIRED SHALL be 0 asynchronously, independent of the clock.
REQ-031 A write coinciding with RESET assertion SHALL be discarded.
REQ-032 After reset, all registers SHALL read 0 and WB_WE SHALL follow its inputs combinationally.
REQ-033 The first state update SHALL occur on the first rising edge after RESET deasserts.

Configuration
REQ-034 With macro WB_BYPASS_EN defined, RDATA_x SHALL return DATA_IN in the same cycle when WB_WE is 1 and RADDR_x equals DESTREG_IN (write-through bypass).
REQ-035 Without WB_BYPASS_EN, RDATA_x SHALL return the old register value until after the write edge, and decode handles the hazard via BUSY.
REQ-036 BUSY and RETIRED behaviour SHALL be identical with and without WB_BYPASS_EN.

Verification
REQ-037 Reset then read all registers: RADDR_A/B swept 0..7 -> RDATA 0x0000, BUSY 0x00, RETIRED 0.
REQ-038 Writeback: OP_IN=01, DESTREG_IN=3, DATA_IN=0xBEEF, one edge -> RADDR_A=3 gives 0xBEEF; then OP_IN=10, DESTREG_IN=0, DATA_IN=0x1234 -> R0 reads 0, RETIRED 2.
REQ-039 Store and NOP: OP_IN=11, DESTREG_IN=5, DATA_IN=0xFFFF -> R5 stays 0, WB_WE=0, RETIRED increments; OP_IN=00 -> RETIRED unchanged.
REQ-040 Scoreboard: ISSUE_VALID=1, ISSUE_REG=4 -> BUSY=0x10; next edge issue 4 and retire 4 together -> BUSY=0x10; next edge retire 4 only -> BUSY=0x00.
REQ-041 Bypass: OP_IN=01, DESTREG_IN=2, DATA_IN=0x00AA, RADDR_B=2 before the edge -> RDATA_B=0x00AA with WB_BYPASS_EN, old value 0x0000 without.
REQ-042 Reset mid-operation and wrap: preload RETIRED to 0xFFFF via 65535 STOREs plus one more -> RETIRED 0x0000; assert RESET asynchronously between edges with OP_IN=01, DESTREG_IN=6 -> R6, BUSY and RETIRED are 0 immediately.
